// File: rtl/sprite_blitter.sv
// sprite_blitter
//   Scans a SPR_W x SPR_H sprite out of an external synchronous ROM, one
//   address per cycle in raster order, and emits VGA plots at origin+offset.
//   Transparent pixels are suppressed and off-screen pixels are clipped.
// Ports
//   clk, resetn         clock, synchronous active-low reset
//   start               draw request, sampled only in IDLE
//   origin_x, origin_y  sprite top-left, latched when start is accepted
//   rom_addr, rom_q     ROM read port (rom_q valid ROM_LAT cycles after addr)
//   x, y, colour, plot  VGA write port
//   busy, done          draw in progress / one-cycle completion pulse
module sprite_blitter #(
    parameter int unsigned SPR_W    = 20,
    parameter int unsigned SPR_H    = 20,
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned COLOUR_W = 9,
    parameter int unsigned ROM_LAT  = 1,
    parameter int unsigned X_W      = 8,
    parameter int unsigned Y_W      = 7,
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned SCREEN_H = 120,
    parameter int unsigned TRANS_EN = 1,
    parameter logic [COLOUR_W-1:0] TRANS_KEY = 9'h1FF
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [X_W-1:0]      origin_x,
    input  logic [Y_W-1:0]      origin_y,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [COLOUR_W-1:0] rom_q,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    localparam int unsigned CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int unsigned RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SPR_W * SPR_H - 1);
    localparam logic [CW-1:0]     COL_LAST  = CW'(SPR_W - 1);
    localparam logic [X_W:0]      SCR_W_L   = (X_W + 1)'(SCREEN_W);
    localparam logic [Y_W:0]      SCR_H_L   = (Y_W + 1)'(SCREEN_H);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
    state_t state_q, state_d;

    logic [CW-1:0]  col;
    logic [RW-1:0]  row;
    logic           vld0;
    logic [X_W-1:0] ox;
    logic [Y_W-1:0] oy;

    // Delay line aligning col/row/valid with rom_q; last stage is aligned.
    logic [CW-1:0] col_d [ROM_LAT];
    logic [RW-1:0] row_d [ROM_LAT];
    logic          v_d   [ROM_LAT];

    logic          pipe_busy;
    logic [X_W:0]  sum_x;
    logic [Y_W:0]  sum_y;
    logic          visible;

    always_comb begin
        pipe_busy = 1'b0;
        for (int unsigned i = 0; i < ROM_LAT; i++) begin
            pipe_busy = pipe_busy | v_d[i];
        end
    end

    // One extra bit on each sum so an 8/7-bit wrap still reads as off-screen.
    always_comb begin
        sum_x   = {1'b0, ox} + {{(X_W + 1 - CW){1'b0}}, col_d[ROM_LAT-1]};
        sum_y   = {1'b0, oy} + {{(Y_W + 1 - RW){1'b0}}, row_d[ROM_LAT-1]};
        visible = !((TRANS_EN != 0) && (rom_q == TRANS_KEY))
                  && (sum_x < SCR_W_L) && (sum_y < SCR_H_L);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (rom_addr == ADDR_LAST) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (!pipe_busy) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            col      <= '0;
            row      <= '0;
            rom_addr <= '0;
            vld0     <= 1'b0;
            ox       <= '0;
            oy       <= '0;
            x        <= '0;
            y        <= '0;
            colour   <= '0;
            plot     <= 1'b0;
            for (int unsigned i = 0; i < ROM_LAT; i++) begin
                col_d[i] <= '0;
                row_d[i] <= '0;
                v_d[i]   <= 1'b0;
            end
        end else begin
            // Address issue
            if (state_q == IDLE && start) begin
                ox       <= origin_x;
                oy       <= origin_y;
                col      <= '0;
                row      <= '0;
                rom_addr <= '0;
                vld0     <= 1'b1;
            end else if (state_q == SCAN && rom_addr != ADDR_LAST) begin
                rom_addr <= rom_addr + 1'b1;
                vld0     <= 1'b1;
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end else begin
                vld0 <= 1'b0;
            end

            // Alignment delay line
            col_d[0] <= col;
            row_d[0] <= row;
            v_d[0]   <= vld0;
            for (int unsigned i = 1; i < ROM_LAT; i++) begin
                col_d[i] <= col_d[i-1];
                row_d[i] <= row_d[i-1];
                v_d[i]   <= v_d[i-1];
            end

            // VGA output register
            if (v_d[ROM_LAT-1]) begin
                x      <= sum_x[X_W-1:0];
                y      <= sum_y[Y_W-1:0];
                colour <= rom_q;
                plot   <= visible;
            end else begin
                plot <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter
//   Directed bench for sprite_blitter: a ROM_LAT=1 instance for the functional
//   cases and a ROM_LAT=3 instance for latency timing. Each instance has its
//   own behavioural ROM; 'sel' chooses which instance a draw is run on.
module tb_sprite_blitter;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start_1 = 1'b0;
    logic       start_3 = 1'b0;
    logic [7:0] ox_in = '0;
    logic [6:0] oy_in = '0;
    logic       sel = 1'b0;
    int         mode = 0;

    logic [8:0] rom_addr_1, rom_addr_3, q_1, q_3, r3a, r3b;
    logic [7:0] x_1, x_3;
    logic [6:0] y_1, y_3;
    logic [8:0] colour_1, colour_3;
    logic       plot_1, plot_3, busy_1, busy_3, done_1, done_3;

    always #5 clk = ~clk;

    sprite_blitter #(.ROM_LAT(1)) dut1 (
        .clk(clk), .resetn(resetn), .start(start_1),
        .origin_x(ox_in), .origin_y(oy_in),
        .rom_addr(rom_addr_1), .rom_q(q_1),
        .x(x_1), .y(y_1), .colour(colour_1),
        .plot(plot_1), .busy(busy_1), .done(done_1)
    );

    sprite_blitter #(.ROM_LAT(3)) dut3 (
        .clk(clk), .resetn(resetn), .start(start_3),
        .origin_x(ox_in), .origin_y(oy_in),
        .rom_addr(rom_addr_3), .rom_q(q_3),
        .x(x_3), .y(y_3), .colour(colour_3),
        .plot(plot_3), .busy(busy_3), .done(done_3)
    );

    // mode 0: pixel value = address; mode 1: all transparent except address 21
    function automatic logic [8:0] rom_f(input logic [8:0] a);
        if (mode == 0) return a;
        return (a == 9'd21) ? 9'h007 : 9'h1FF;
    endfunction

    always @(posedge clk) begin
        q_1 <= rom_f(rom_addr_1);
        r3a <= rom_f(rom_addr_3);
        r3b <= r3a;
        q_3 <= r3b;
    end

    logic [7:0] s_x;
    logic [6:0] s_y;
    logic [8:0] s_colour, s_addr;
    logic       s_plot, s_busy, s_done;
    assign s_x      = sel ? x_3 : x_1;
    assign s_y      = sel ? y_3 : y_1;
    assign s_colour = sel ? colour_3 : colour_1;
    assign s_addr   = sel ? rom_addr_3 : rom_addr_1;
    assign s_plot   = sel ? plot_3 : plot_1;
    assign s_busy   = sel ? busy_3 : busy_1;
    assign s_done   = sel ? done_3 : done_1;

    int checks = 0;
    int errors = 0;

    int n_plot, first_c, done_at, map_bad, clip_bad, busy_bad;
    int cur_ox, cur_oy, n_done;
    logic [7:0] fx, lx;
    logic [6:0] fy, ly;
    logic [8:0] fc, lc;
    logic       done_after, busy_after;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) start_3 = v;
        else     start_1 = v;
    endtask

    // Leaves the bench at the negedge just after the accepting edge (c = 0).
    task automatic start_draw(input int ox, input int oy);
        @(negedge clk);
        ox_in  = ox[7:0];
        oy_in  = oy[6:0];
        cur_ox = ox;
        cur_oy = oy;
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        ox_in = 8'hAA;
        oy_in = 7'h55;
    endtask

    // Samples each cycle after the accepting edge; c counts edges since it.
    task automatic collect(input int pulse_at, input bit restart);
        int dx, dy;
        n_plot = 0; first_c = -1; done_at = -1;
        map_bad = 0; clip_bad = 0; busy_bad = 0;
        done_after = 1'bx; busy_after = 1'bx;
        for (int c = 1; c <= 1000; c++) begin
            @(negedge clk);
            if (c == pulse_at) set_start(1'b1);
            else if (c == pulse_at + 1) set_start(1'b0);
            if (s_plot) begin
                n_plot++;
                if (first_c < 0) begin
                    first_c = c; fx = s_x; fy = s_y; fc = s_colour;
                end
                lx = s_x; ly = s_y; lc = s_colour;
                if (s_x >= 8'd160 || s_y >= 7'd120) clip_bad++;
                dx = int'(s_x) - cur_ox;
                dy = int'(s_y) - cur_oy;
                if (mode == 0 && int'(s_colour) != dy * 20 + dx) map_bad++;
            end
            if (s_done) begin
                done_at = c;
                if (restart) set_start(1'b1);
                @(negedge clk);
                done_after = s_done;
                busy_after = s_busy;
                break;
            end else if (!s_busy) begin
                busy_bad++;
            end
        end
    endtask

    initial begin
        // Reset with start asserted
        resetn  = 1'b0;
        start_1 = 1'b1;
        start_3 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_plot1", plot_1, 0);
        check("rst_busy1", busy_1, 0);
        check("rst_done1", done_1, 0);
        check("rst_x1", x_1, 0);
        check("rst_y1", y_1, 0);
        check("rst_addr1", rom_addr_1, 0);
        check("rst_busy3", busy_3, 0);
        check("rst_plot3", plot_3, 0);
        start_1 = 1'b0;
        start_3 = 1'b0;
        resetn  = 1'b1;

        // Basic draw, identity ROM
        sel = 1'b0; mode = 0;
        start_draw(10, 5);
        check("basic_busy0", s_busy, 1);
        check("basic_addr0", s_addr, 0);
        collect(-1, 1'b0);
        check("basic_nplot", n_plot, 400);
        check("basic_first_c", first_c, 2);
        check("basic_fx", fx, 10);
        check("basic_fy", fy, 5);
        check("basic_fc", fc, 0);
        check("basic_lx", lx, 29);
        check("basic_ly", ly, 24);
        check("basic_lc", lc, 399);
        check("basic_done_at", done_at, 402);
        check("basic_done_len", done_after, 0);
        check("basic_map", map_bad, 0);
        check("basic_busy", busy_bad, 0);

        // Transparency
        mode = 1;
        start_draw(10, 5);
        collect(-1, 1'b0);
        check("trans_nplot", n_plot, 1);
        check("trans_x", fx, 11);
        check("trans_y", fy, 6);
        check("trans_c", fc, 7);
        check("trans_done_at", done_at, 402);

        // Clipping at bottom-right
        mode = 0;
        start_draw(150, 110);
        collect(-1, 1'b0);
        check("clip_nplot", n_plot, 100);
        check("clip_bad", clip_bad, 0);
        check("clip_fx", fx, 150);
        check("clip_fy", fy, 110);
        check("clip_lx", lx, 159);
        check("clip_ly", ly, 119);
        check("clip_lc", lc, 189);
        check("clip_map", map_bad, 0);

        // x sum wraps past 255: everything is off-screen
        start_draw(250, 100);
        collect(-1, 1'b0);
        check("wrap_nplot", n_plot, 0);
        check("wrap_done_at", done_at, 402);

        // Handshake: start mid-draw and on DONE ignored, then accepted in IDLE
        start_draw(10, 5);
        collect(50, 1'b1);
        check("hs_nplot", n_plot, 400);
        check("hs_done_at", done_at, 402);
        check("hs_idle_busy", busy_after, 0);
        ox_in = 8'd20; oy_in = 7'd30; cur_ox = 20; cur_oy = 30;
        @(negedge clk);
        set_start(1'b0);
        check("hs_restart_busy", s_busy, 1);
        check("hs_restart_addr", s_addr, 0);
        ox_in = 8'd0; oy_in = 7'd0;
        collect(-1, 1'b0);
        check("hs2_nplot", n_plot, 400);
        check("hs2_fx", fx, 20);
        check("hs2_fy", fy, 30);
        check("hs2_done_at", done_at, 402);
        check("hs2_map", map_bad, 0);

        // ROM_LAT = 3 instance
        sel = 1'b1;
        start_draw(10, 5);
        collect(-1, 1'b0);
        check("lat3_nplot", n_plot, 400);
        check("lat3_first_c", first_c, 4);
        check("lat3_lc", lc, 399);
        check("lat3_done_at", done_at, 404);
        check("lat3_map", map_bad, 0);

        // Abort mid-draw
        sel = 1'b0;
        start_draw(10, 5);
        repeat (202) @(negedge clk);
        check("abort_pre_plot", s_plot, 1);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check("abort_plot", s_plot, 0);
        check("abort_busy", s_busy, 0);
        check("abort_done", s_done, 0);
        check("abort_addr", s_addr, 0);
        n_plot = 0; n_done = 0;
        for (int i = 0; i < 450; i++) begin
            @(negedge clk);
            if (s_plot) n_plot++;
            if (s_done) n_done++;
        end
        check("abort_no_plot", n_plot, 0);
        check("abort_no_done", n_done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
